frame_capture_ctrl: RTL and testbench
=====================================

Name: frame_capture_ctrl

Overview:
- Sequences OV7670 camera capture into the dual-port M9K frame buffer.
- Frames on VSYNC/HREF, packs RGB565 byte pairs into RGB332, and generates the linear write address and write enable.
- Signals frame completion to the image processor.
- Sits between the camera GPIO pins and the frame-buffer write port, in the camera pixel-clock domain.

Parameters:
- SCREEN_WIDTH, 176, pixels per stored line.
- SCREEN_HEIGHT, 144, lines per stored frame.
- ADDR_W, 15, frame-buffer address width; SCREEN_WIDTH*SCREEN_HEIGHT must not exceed 2^ADDR_W.

Ports:
- CLOCK  in  1  camera pixel clock; single clock for the block.
- RESET  in  1  synchronous, active-high reset.
- VSYNC  in  1  camera vertical sync, high between frames.
- HREF  in  1  camera line-valid.
- DATA_IN  in  8  camera byte bus.
- CAPTURE_REQ  in  1  one-cycle request to arm a capture.
- CONTINUOUS  in  1  1 = re-arm automatically after each frame.
- TEST_MODE  in  1  select test pattern (see Optional Feature).
- W_ADDR  out  ADDR_W  frame-buffer write address.
- W_DATA  out  8  RGB332 pixel.
- W_EN  out  1  frame-buffer write strobe.
- X  out  10  current pixel column.
- Y  out  10  current line.
- BUSY  out  1  high in WAIT_VSYNC or CAPTURE.
- FRAME_DONE  out  1  one-cycle pulse at end of frame.
- SHORT_FRAME  out  1  sticky; set if a frame ended with fewer than SCREEN_HEIGHT lines.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; byte phase 0.
  - Reset takes effect on any cycle, including mid-frame; no partial write occurs in the reset cycle.
- Edge detection: VSYNC and HREF registered once; edges are taken from registered vs current value.
- States:
  - IDLE: CAPTURE_REQ=1 -> WAIT_VSYNC. CAPTURE_REQ is ignored in every other state.
  - WAIT_VSYNC: VSYNC falling edge -> CAPTURE; X, Y, W_ADDR and line base cleared.
  - CAPTURE:
    - Per HREF rising edge: phase=0, X=0.
    - While HREF=1, phase toggles each cycle. Phase 0 latches hi byte; phase 1 forms pixel {hi[7:5], hi[2:0], DATA_IN[4:3]}.
    - On each phase-1 byte, if X<SCREEN_WIDTH and Y<SCREEN_HEIGHT: next cycle W_EN=1, W_DATA=pixel, W_ADDR=line_base+X. X then increments. Latency is 1 cycle from second byte to W_EN.
    - Pixels with X>=SCREEN_WIDTH: W_EN=0 and X saturates at SCREEN_WIDTH.
    - HREF falling edge with an odd byte pending: the byte is discarded.
    - HREF falling edge after at least one byte: Y+=1 and line_base+=SCREEN_WIDTH. Y saturates at SCREEN_HEIGHT; lines beyond it are not written.
    - VSYNC rising edge -> DONE.
  - DONE (one cycle):
    - FRAME_DONE=1.
    - If Y<SCREEN_HEIGHT, SHORT_FRAME set. It clears only on RESET or a new CAPTURE_REQ.
    - Next state is WAIT_VSYNC if CONTINUOUS=1, else IDLE.
- Simultaneous events:
  - VSYNC rise while HREF=1: the frame ends; a pending half pixel is discarded and no write occurs.
  - HREF and VSYNC edges in the same cycle: VSYNC wins.
- W_ADDR never exceeds SCREEN_WIDTH*SCREEN_HEIGHT-1 while W_EN=1.
- Address arithmetic: no multiplier; adds only.

Optional Feature:
- Macro: CAPTURE_TEST_PATTERN_EN.
- Defined: when TEST_MODE=1, W_DATA is replaced by a colour bar from X[7:5]:
  - 0 = 8'hE0 red
  - 1 = 8'h1C green
  - 2 = 8'h03 blue
  - 3 = 8'hFF white
  - 4-7 = 8'h00
- Timing, addressing and W_EN are unchanged.
- Undefined: TEST_MODE is ignored and W_DATA is always camera data.

Decomposition:
- Shared package cam_pkg:
  - state typedef (IDLE, WAIT_VSYNC, CAPTURE, DONE);
  - RGB332 colour constants (RED, GREEN, BLUE, WHITE);
  - default screen dimensions.
- One natural sub-module, rgb565_to_332: byte-pair packer holding phase, hi-byte latch and pixel-valid output.

Test Plan:
- Full frame: CAPTURE_REQ, VSYNC falling, 144 lines of 352 bytes with byte pair (8'hF8, 8'h1F) -> 25344 writes, W_DATA=8'hE3, last W_ADDR=25343, one FRAME_DONE, SHORT_FRAME=0, state IDLE.
- Overlong line: 400 bytes per line -> exactly 176 writes per line; address of line 1, pixel 0 = 176.
- Short frame: VSYNC rising after 100 lines, CONTINUOUS=1 -> FRAME_DONE, SHORT_FRAME=1, state WAIT_VSYNC; next frame restarts at W_ADDR=0.
- Odd byte at line end: 3 bytes in a line -> 1 write; next line X starts at 0.
- Reset mid-frame at line 50 -> next cycle all outputs 0, state IDLE; no writes until the next CAPTURE_REQ plus a VSYNC falling edge.
- CAPTURE_TEST_PATTERN_EN defined, TEST_MODE=1 -> pixels 0-31 = 8'hE0, 32-63 = 8'h1C, 64-95 = 8'h03, 96-127 = 8'hFF, 128-175 = 8'h00.

Source files
------------

// File: rtl/frame_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cam_pkg
// Description : Shared types and constants for the OV7670 frame-capture path.
//               Provides the capture FSM state type, the RGB332 colour-bar
//               constants and the default stored-frame dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } cam_state_t;

    // RGB332 colours used by the optional colour-bar pattern.
    localparam logic [7:0] c_RGB332_RED   = 8'hE0;
    localparam logic [7:0] c_RGB332_GREEN = 8'h1C;
    localparam logic [7:0] c_RGB332_BLUE  = 8'h03;
    localparam logic [7:0] c_RGB332_WHITE = 8'hFF;
    localparam logic [7:0] c_RGB332_BLACK = 8'h00;

    // Default stored-frame geometry (QCIF) and frame-buffer address width.
    localparam int c_DEFAULT_SCREEN_WIDTH  = 176;
    localparam int c_DEFAULT_SCREEN_HEIGHT = 144;
    localparam int c_DEFAULT_ADDR_W        = 15;

    // Colour bar selected by column bits [7:5]: 32-pixel wide bars, black
    // beyond the fourth bar.
    function automatic logic [7:0] colour_bar(input logic [2:0] bar);
        logic [7:0] colour;
        case (bar)
            3'd0:    colour = c_RGB332_RED;
            3'd1:    colour = c_RGB332_GREEN;
            3'd2:    colour = c_RGB332_BLUE;
            3'd3:    colour = c_RGB332_WHITE;
            default: colour = c_RGB332_BLACK;
        endcase
        return colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : frame_capture_ctrl_if
// Description : Frame-buffer write port (address, RGB332 data, write strobe).
//               master : driven by the capture controller
//               slave  : observed by the frame-buffer write side
// Ports       : W_ADDR [ADDR_W] write address, W_DATA [8] pixel, W_EN strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_capture_ctrl_if
    import cam_pkg::*;
#(
    parameter int ADDR_W = c_DEFAULT_ADDR_W
);
    logic [ADDR_W-1:0] W_ADDR;
    logic [7:0]        W_DATA;
    logic              W_EN;

    modport master (output W_ADDR, output W_DATA, output W_EN);
    modport slave  (input  W_ADDR, input  W_DATA, input  W_EN);
endinterface
`default_nettype wire

// File: rtl/frame_capture_ctrl_rgb565_to_332.sv
`default_nettype none
// ============================================================================
// Module      : rgb565_to_332
// Description : Byte-pair packer. Latches the RGB565 high byte on phase 0 and,
//               on the phase-1 byte, presents the RGB332 pixel
//               {hi[7:5], hi[2:0], lo[4:3]} with a one-cycle valid.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - line start (forces phase 0 for this byte)
//               i_byte_en       - a camera byte is accepted this cycle
//               i_data   [8]    - camera byte
//               o_pixel  [8]    - packed RGB332 pixel (valid with o_pixel_valid)
//               o_pixel_valid   - second byte of a pair accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rgb565_to_332 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_byte_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_pixel,
    output logic       o_pixel_valid
);
    logic       r_phase;
    logic [5:0] r_hi;     // only the bits that survive packing are kept
    logic       w_phase;

    assign w_phase       = i_start ? 1'b0 : r_phase;
    assign o_pixel_valid = i_byte_en & w_phase;
    assign o_pixel       = {r_hi, i_data[4:3]};

    // Any cycle without an accepted byte returns to phase 0, so an odd byte
    // left at the end of a line is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_hi    <= 6'd0;
        end else if (i_byte_en) begin
            if (!w_phase) begin
                r_hi    <= {i_data[7:5], i_data[2:0]};
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
            end
        end else begin
            r_phase <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_capture_ctrl
// Description : OV7670 capture sequencer. Frames on VSYNC/HREF, packs RGB565
//               byte pairs into RGB332, generates the linear frame-buffer
//               write address/strobe and pulses FRAME_DONE at end of frame.
//               Runs entirely in the camera pixel-clock domain.
// Ports       : CLOCK, RESET (sync, active high)
//               VSYNC, HREF, DATA_IN[8]      - camera pins
//               CAPTURE_REQ, CONTINUOUS      - capture control
//               TEST_MODE                    - colour-bar select
//               fb (master)                  - W_ADDR/W_DATA/W_EN write port
//               X[10], Y[10]                 - current column / line
//               BUSY, FRAME_DONE, SHORT_FRAME - status
// Options     : `define CAPTURE_TEST_PATTERN_EN to replace W_DATA with colour
//               bars while TEST_MODE=1; otherwise TEST_MODE is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int SCREEN_WIDTH  = c_DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = c_DEFAULT_SCREEN_HEIGHT,
    parameter int ADDR_W        = c_DEFAULT_ADDR_W   // WIDTH*HEIGHT <= 2**ADDR_W
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                VSYNC,
    input  logic                HREF,
    input  logic [7:0]          DATA_IN,
    input  logic                CAPTURE_REQ,
    input  logic                CONTINUOUS,
    input  logic                TEST_MODE,
    frame_capture_ctrl_if.master fb,
    output logic [9:0]          X,
    output logic [9:0]          Y,
    output logic                BUSY,
    output logic                FRAME_DONE,
    output logic                SHORT_FRAME
);
    localparam logic [9:0]        c_WIDTH_X  = 10'(SCREEN_WIDTH);
    localparam logic [9:0]        c_HEIGHT_Y = 10'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] c_WIDTH_A  = ADDR_W'(SCREEN_WIDTH);

    cam_state_t r_state, w_next_state;

    logic              r_vsync_q, r_href_q;
    logic              w_vsync_rise, w_vsync_fall, w_href_rise, w_href_fall;
    logic              w_in_capture, w_byte_en;
    logic [7:0]        w_pixel, w_pixel_out;
    logic              w_pixel_valid;
    logic [9:0]        r_x, r_y;
    logic [ADDR_W-1:0] r_line_base, r_w_addr;
    logic [7:0]        r_w_data;
    logic              r_w_en, r_short, r_line_bytes;

    assign w_vsync_rise = VSYNC & ~r_vsync_q;
    assign w_vsync_fall = ~VSYNC & r_vsync_q;
    assign w_href_rise  = HREF & ~r_href_q;
    assign w_href_fall  = ~HREF & r_href_q;

    // VSYNC rising ends the frame and overrides every line/byte event.
    assign w_in_capture = (r_state == CAPTURE) && !w_vsync_rise;
    assign w_byte_en    = w_in_capture && HREF;

    rgb565_to_332 u_packer (
        .clk           (CLOCK),
        .rst           (RESET),
        .i_start       (w_href_rise),
        .i_byte_en     (w_byte_en),
        .i_data        (DATA_IN),
        .o_pixel       (w_pixel),
        .o_pixel_valid (w_pixel_valid)
    );

`ifdef CAPTURE_TEST_PATTERN_EN
    assign w_pixel_out = TEST_MODE ? colour_bar(r_x[7:5]) : w_pixel;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = TEST_MODE;
    assign w_pixel_out        = w_pixel;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        BUSY         = 1'b0;
        FRAME_DONE   = 1'b0;
        case (r_state)
            IDLE: begin
                if (CAPTURE_REQ) w_next_state = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                BUSY = 1'b1;
                if (w_vsync_fall) w_next_state = CAPTURE;
            end
            CAPTURE: begin
                BUSY = 1'b1;
                if (w_vsync_rise) w_next_state = DONE;
            end
            DONE: begin
                FRAME_DONE   = 1'b1;
                w_next_state = CONTINUOUS ? WAIT_VSYNC : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Position, address and write-port datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_vsync_q    <= 1'b0;
            r_href_q     <= 1'b0;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_line_base  <= '0;
            r_w_addr     <= '0;
            r_w_data     <= 8'd0;
            r_w_en       <= 1'b0;
            r_short      <= 1'b0;
            r_line_bytes <= 1'b0;
        end else begin
            r_vsync_q <= VSYNC;
            r_href_q  <= HREF;
            r_w_en    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (CAPTURE_REQ) r_short <= 1'b0;
                end
                WAIT_VSYNC: begin
                    if (w_vsync_fall) begin
                        r_x          <= 10'd0;
                        r_y          <= 10'd0;
                        r_line_base  <= '0;
                        r_w_addr     <= '0;
                        r_line_bytes <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (w_vsync_rise) begin
                        // Short-frame flag rises together with FRAME_DONE.
                        if (r_y < c_HEIGHT_Y) r_short <= 1'b1;
                    end else begin
                        if (w_href_rise) r_x <= 10'd0;
                        if (w_byte_en) r_line_bytes <= 1'b1;
                        if (w_pixel_valid && (r_x < c_WIDTH_X)) begin
                            r_x <= r_x + 10'd1;
                            if (r_y < c_HEIGHT_Y) begin
                                r_w_en   <= 1'b1;
                                r_w_data <= w_pixel_out;
                                r_w_addr <= r_line_base + ADDR_W'(r_x);
                            end
                        end
                        if (w_href_fall) begin
                            r_line_bytes <= 1'b0;
                            // Line base advances by addition only and stops
                            // with Y, keeping W_ADDR inside the frame.
                            if (r_line_bytes && (r_y < c_HEIGHT_Y)) begin
                                r_y         <= r_y + 10'd1;
                                r_line_base <= r_line_base + c_WIDTH_A;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fb.W_ADDR   = r_w_addr;
    assign fb.W_DATA   = r_w_data;
    assign fb.W_EN     = r_w_en;
    assign X           = r_x;
    assign Y           = r_y;
    assign SHORT_FRAME = r_short;
endmodule
`default_nettype wire

// File: tb/tb_frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_capture_ctrl
// Description : Self-checking bench for frame_capture_ctrl. Random camera
//               bytes are compared against a frame-level reference model
//               (line/pixel counting with plain arithmetic).
// Options     : honours CAPTURE_TEST_PATTERN_EN for the colour-bar model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_capture_ctrl;
    localparam int W  = 176;
    localparam int H  = 144;
    localparam int AW = 15;

    logic       clk = 1'b0;
    logic       rst, vsync, href, capture_req, continuous, test_mode;
    logic [7:0] data;
    logic [9:0] x, y;
    logic       busy, frame_done, short_frame;

    frame_capture_ctrl_if #(.ADDR_W(AW)) fb ();

    frame_capture_ctrl #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .ADDR_W       (AW)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .VSYNC       (vsync),
        .HREF        (href),
        .DATA_IN     (data),
        .CAPTURE_REQ (capture_req),
        .CONTINUOUS  (continuous),
        .TEST_MODE   (test_mode),
        .fb          (fb),
        .X           (x),
        .Y           (y),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done),
        .SHORT_FRAME (short_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed writes / pulses (written only by the monitor).
    int         got_addr[$];
    logic [7:0] got_data[$];
    int         done_cnt = 0;
    int         oob_cnt  = 0;

    // Reference model state.
    int         exp_addr[$];
    logic [7:0] exp_data[$];
    int         m_line      = 0;
    bit         m_armed     = 1'b0;
    bit         m_capturing = 1'b0;
    int         lat_err     = 0;

    always @(negedge clk) begin
        if (fb.W_EN === 1'b1) begin
            got_addr.push_back(int'(fb.W_ADDR));
            got_data.push_back(fb.W_DATA);
            if (int'(fb.W_ADDR) >= W * H) oob_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] m_pixel(input logic [7:0] hi, input logic [7:0] lo,
                                           input int p);
`ifdef CAPTURE_TEST_PATTERN_EN
        if (test_mode) begin
            if (p < 32)       return 8'hE0;
            else if (p < 64)  return 8'h1C;
            else if (p < 96)  return 8'h03;
            else if (p < 128) return 8'hFF;
            else              return 8'h00;
        end
`endif
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    // Number of differing entries between the writes seen since g0 and the
    // writes predicted since e0 (over the common length).
    function automatic int mism(input int g0, input int e0);
        int n  = 0;
        int ng = got_addr.size() - g0;
        int ne = exp_addr.size() - e0;
        for (int i = 0; i < ng && i < ne; i++)
            if (got_addr[g0+i] != exp_addr[e0+i] || got_data[g0+i] !== exp_data[e0+i]) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
        m_armed = 1'b1;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        if (m_armed) begin
            m_armed     = 1'b0;
            m_capturing = 1'b1;
            m_line      = 0;
        end
    endtask

    task automatic end_frame(output logic fd, output logic sf);
        vsync = 1'b1;
        tick();
        fd = frame_done;
        sf = short_frame;
        m_capturing = 1'b0;
        if (continuous) m_armed = 1'b1;
        tick();
    endtask

    // One HREF line; also checks the W_EN produced one cycle after each byte.
    task automatic send_line(input int nbytes, input bit pat);
        logic [7:0] b, hi;
        logic       exp_w;
        int         p;
        hi = 8'd0;
        for (int k = 0; k < nbytes; k++) begin
            b    = pat ? ((k % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
            href = 1'b1;
            data = b;
            tick();
            exp_w = 1'b0;
            if (k % 2 == 1) begin
                p = k / 2;
                if (m_capturing && p < W && m_line < H) begin
                    exp_w = 1'b1;
                    exp_addr.push_back(m_line * W + p);
                    exp_data.push_back(m_pixel(hi, b, p));
                end
            end else begin
                hi = b;
            end
            if (fb.W_EN !== exp_w) lat_err++;
        end
        href = 1'b0;
        data = 8'd0;
        tick();
        if (fb.W_EN !== 1'b0) lat_err++;
        repeat (3) tick();
        if (nbytes > 0 && m_capturing) m_line++;
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'd0;
        capture_req = 1'b0; continuous = 1'b0; test_mode = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({fb.W_ADDR, fb.W_DATA, fb.W_EN, x, y, busy, frame_done, short_frame} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d data=%0h en=%b x=%0d y=%0d busy=%b fd=%b sf=%b expected all 0",
                     fb.W_ADDR, fb.W_DATA, fb.W_EN, x, y, busy, frame_done, short_frame);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_req: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_full_frame();
        int g0 = got_addr.size();
        int e0 = exp_addr.size();
        int d0 = done_cnt;
        int l0 = lat_err;
        logic fd, sf;
        continuous = 1'b0;
        arm();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_busy: got %b expected 1", busy);
        end
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b1);
        n_checks++;
        if (y !== 10'(H)) begin
            n_fail++;
            $display("FAIL full_y: got %0d expected %0d", y, H);
        end
        end_frame(fd, sf);
        n_checks++;
        if (got_addr.size() - g0 !== W * H) begin
            n_fail++;
            $display("FAIL full_count: got %0d expected %0d", got_addr.size() - g0, W * H);
        end
        n_checks++;
        if (mism(g0, e0) !== 0) begin
            n_fail++;
            $display("FAIL full_data: got %0d mismatching writes expected 0", mism(g0, e0));
        end
        if (got_addr.size() > g0) begin
            n_checks++;
            if (got_addr[got_addr.size()-1] !== W * H - 1 || got_data[got_data.size()-1] !== 8'hE3) begin
                n_fail++;
                $display("FAIL full_last: got addr=%0d data=%0h expected addr=%0d data=e3",
                         got_addr[got_addr.size()-1], got_data[got_data.size()-1], W * H - 1);
            end
        end
        n_checks++;
        if (fd !== 1'b1 || done_cnt - d0 !== 1 || sf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got fd=%b pulses=%0d sf=%b expected fd=1 pulses=1 sf=0",
                     fd, done_cnt - d0, sf);
        end
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle: got busy=%b fd=%b expected 0 0", busy, frame_done);
        end
        n_checks++;
        if (lat_err - l0 !== 0 || oob_cnt !== 0) begin
            n_fail++;
            $display("FAIL full_wen_timing: got %0d timing errors %0d out-of-range expected 0 0",
                     lat_err - l0, oob_cnt);
        end
    endtask

    task automatic test_overlong();
        int g0 = got_addr.size();
        int e0 = exp_addr.size();
        logic fd, sf;
        arm();
        vsync_pulse();
        for (int l = 0; l < 3; l++) send_line(400, 1'b0);
        n_checks++;
        if (x !== 10'(W)) begin
            n_fail++;
            $display("FAIL overlong_x_sat: got %0d expected %0d", x, W);
        end
        end_frame(fd, sf);
        n_checks++;
        if (got_addr.size() - g0 !== 3 * W || mism(g0, e0) !== 0) begin
            n_fail++;
            $display("FAIL overlong_writes: got %0d writes %0d mismatches expected %0d 0",
                     got_addr.size() - g0, mism(g0, e0), 3 * W);
        end
        if (got_addr.size() > g0 + W) begin
            n_checks++;
            if (got_addr[g0+W] !== W) begin
                n_fail++;
                $display("FAIL overlong_line1_addr: got %0d expected %0d", got_addr[g0+W], W);
            end
        end
        n_checks++;
        if (fd !== 1'b1 || sf !== 1'b1) begin
            n_fail++;
            $display("FAIL overlong_short: got fd=%b sf=%b expected 1 1", fd, sf);
        end
    endtask

    task automatic test_short_continuous();
        int g0 = got_addr.size();
        int e0 = exp_addr.size();
        int g1, e1;
        logic fd, sf;
        continuous = 1'b1;
        arm();
        n_checks++;
        if (short_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL req_clears_short: got %b expected 0", short_frame);
        end
        vsync_pulse();
        for (int l = 0; l < 100; l++) send_line(int'($urandom_range(1, 60)), 1'b0);
        end_frame(fd, sf);
        n_checks++;
        if (fd !== 1'b1 || sf !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_cont: got fd=%b sf=%b busy=%b expected 1 1 1", fd, sf, busy);
        end
        n_checks++;
        if (got_addr.size() - g0 !== exp_addr.size() - e0 || mism(g0, e0) !== 0) begin
            n_fail++;
            $display("FAIL short_writes: got %0d writes %0d mismatches expected %0d 0",
                     got_addr.size() - g0, mism(g0, e0), exp_addr.size() - e0);
        end
        g1 = got_addr.size();
        e1 = exp_addr.size();
        vsync_pulse();
        send_line(20, 1'b0);
        send_line(20, 1'b0);
        continuous = 1'b0;
        end_frame(fd, sf);
        n_checks++;
        if (got_addr.size() - g1 !== 20 || mism(g1, e1) !== 0 ||
            (got_addr.size() > g1 && got_addr[g1] !== 0)) begin
            n_fail++;
            $display("FAIL rearm_restart: got %0d writes %0d mismatches expected 20 0 from addr 0",
                     got_addr.size() - g1, mism(g1, e1));
        end
        n_checks++;
        if (busy !== 1'b0 || short_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_idle: got busy=%b sf=%b expected 0 1", busy, short_frame);
        end
    endtask

    task automatic test_odd_byte();
        int g0 = got_addr.size();
        int e0 = exp_addr.size();
        int d0 = done_cnt;
        arm();
        vsync_pulse();
        send_line(3, 1'b0);
        n_checks++;
        if (x !== 10'd1 || y !== 10'd1 || got_addr.size() - g0 !== 1) begin
            n_fail++;
            $display("FAIL odd_line: got x=%0d y=%0d writes=%0d expected 1 1 1",
                     x, y, got_addr.size() - g0);
        end
        send_line(4, 1'b0);
        n_checks++;
        if (got_addr.size() - g0 !== 3 || mism(g0, e0) !== 0) begin
            n_fail++;
            $display("FAIL odd_next_line: got %0d writes %0d mismatches expected 3 0",
                     got_addr.size() - g0, mism(g0, e0));
        end
        // VSYNC rises on the second byte of a pair while HREF is high.
        href = 1'b1; data = 8'($urandom);
        tick();
        data = 8'($urandom); vsync = 1'b1;
        tick();
        m_capturing = 1'b0;
        href = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (got_addr.size() - g0 !== 3 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL vsync_in_href: got writes=%0d pulses=%0d busy=%b expected 3 1 0",
                     got_addr.size() - g0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int g0 = got_addr.size();
        int e0 = exp_addr.size();
        int g1;
        logic fd, sf;
        arm();
        vsync_pulse();
        for (int l = 0; l < 50; l++) send_line(int'($urandom_range(2, 40)), 1'b0);
        href = 1'b1; data = 8'($urandom);
        tick();
        data = 8'($urandom); rst = 1'b1;
        tick();
        n_checks++;
        if ({fb.W_ADDR, fb.W_DATA, fb.W_EN, x, y, busy, frame_done, short_frame} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got addr=%0d data=%0h en=%b x=%0d y=%0d busy=%b sf=%b expected all 0",
                     fb.W_ADDR, fb.W_DATA, fb.W_EN, x, y, busy, short_frame);
        end
        rst = 1'b0; href = 1'b0;
        m_armed = 1'b0; m_capturing = 1'b0;
        tick();
        n_checks++;
        if (got_addr.size() - g0 !== exp_addr.size() - e0 || mism(g0, e0) !== 0) begin
            n_fail++;
            $display("FAIL pre_reset_writes: got %0d writes %0d mismatches expected %0d 0",
                     got_addr.size() - g0, mism(g0, e0), exp_addr.size() - e0);
        end
        g1 = got_addr.size();
        vsync_pulse();
        send_line(10, 1'b0);
        arm();
        send_line(10, 1'b0);
        n_checks++;
        if (got_addr.size() !== g1) begin
            n_fail++;
            $display("FAIL no_write_after_reset: got %0d writes expected 0", got_addr.size() - g1);
        end
        g0 = got_addr.size();
        e0 = exp_addr.size();
        vsync_pulse();
        send_line(10, 1'b0);
        end_frame(fd, sf);
        n_checks++;
        if (got_addr.size() - g0 !== 5 || mism(g0, e0) !== 0 ||
            (got_addr.size() > g0 && got_addr[g0] !== 0)) begin
            n_fail++;
            $display("FAIL post_reset_frame: got %0d writes %0d mismatches expected 5 0 from addr 0",
                     got_addr.size() - g0, mism(g0, e0));
        end
    endtask

    task automatic test_pattern();
        int g0 = got_addr.size();
        int e0 = exp_addr.size();
        int l0 = lat_err;
        logic fd, sf;
        test_mode = 1'b1;
        arm();
        vsync_pulse();
        send_line(2 * W, 1'b0);
        end_frame(fd, sf);
        test_mode = 1'b0;
        n_checks++;
        if (got_addr.size() - g0 !== W || mism(g0, e0) !== 0 || lat_err !== l0) begin
            n_fail++;
            $display("FAIL test_mode_line: got %0d writes %0d mismatches %0d timing errors expected %0d 0 0",
                     got_addr.size() - g0, mism(g0, e0), lat_err - l0, W);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overlong();
        test_short_continuous();
        test_odd_byte();
        test_reset_mid_frame();
        test_pattern();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
